mru_wb_bridge: RTL and testbench
================================

// Module: mru_wb_bridge
// PURPOSE
// - Memory request unit: arbitrates CPU instruction-fetch and byte data-access ports onto one classic Wishbone B4 master bus.
// - Sits between the core pipeline and the system memory/bus fabric.
// - Handles halfword-aligned 16/32-bit instruction fetch, including two-cycle fetches that straddle a word, and byte-lane steering.
// PARAMETERS
// - DATA_PRIO  1  1: data port wins a simultaneous request; 0: instruction port wins
// PORTS
// - clk_i       in   1   single system clock; all logic on posedge
// - rst_i       in   1   reset, asynchronous, active-low
// - ins_en      in   1   instruction fetch request, held until ins_ack
// - ins_addr    in   31  halfword address (byte address [31:1])
// - ins_ext     in   1   1: 32-bit instruction, 0: 16-bit instruction
// - ins_stl     out  1   ins_en & ~ins_ack (combinational)
// - ins_ack     out  1   1-cycle pulse; ins_data valid
// - ins_data    out  32  fetched instruction (16-bit: [31:16]=0)
// - mem_en      in   1   data request, held until mem_ack
// - mem_addr    in   32  byte address
// - mem_we      in   1   1 write, 0 read
// - mem_data_i  in   8   write byte
// - mem_stl     out  1   mem_en & ~mem_ack (combinational)
// - mem_ack     out  1   1-cycle pulse; mem_data_o valid for reads
// - mem_data_o  out  8   read byte (holds last value)
// - dat_i       in   32  WB read data
// - ack_i       in   1   WB acknowledge
// - dat_o       out  32  WB write data
// - adr_o       out  30  WB word address
// - sel_o       out  4   WB byte select
// - cyc_o,stb_o out  1   WB cycle/strobe, always equal
// - we_o        out  1   WB write enable
// BEHAVIOUR
// - FSM: IDLE, INS_A, INS_B, MEM; all bus outputs registered.
// - Reset (async, active-low): state IDLE; cyc_o/stb_o/we_o/ins_ack/mem_ack=0; sel_o=0; adr_o=0; dat_o=0; ins_data=0; mem_data_o=0.
// - Reset mid-transaction drops cyc_o/stb_o immediately; the request is lost, no ack.
// - IDLE: sample requests at posedge; simultaneous requests resolved by DATA_PRIO; the winner's bus cycle starts next cycle.
// - MEM: adr_o=mem_addr[31:2]; sel_o=1<<mem_addr[1:0]; dat_o={4{mem_data_i}}; we_o=mem_we.
//   - Lanes are little-endian.
//   - On ack_i: the read byte is taken from lane mem_addr[1:0]; mem_ack pulses; return to IDLE.
// - INS_A: adr_o=ins_addr[30:1]; sel_o=4'hF; we_o=0. On ack_i:
//   - ins_addr[0]=0, ext=1: ins_data=dat_i.
//   - ins_addr[0]=0, ext=0: ins_data={16'h0,dat_i[15:0]}.
//   - ins_addr[0]=1, ext=0: ins_data={16'h0,dat_i[31:16]}.
//   - ins_addr[0]=1, ext=1: latch dat_i[31:16] as the low half and go to INS_B.
//   - All other cases: ins_ack pulses; return to IDLE.
// - INS_B: adr_o=ins_addr[30:1]+1, wrapping at 2^30. On ack_i: ins_data[31:16]=dat_i[15:0]; ins_ack pulses; return to IDLE.
// - Handshake and timing:
//   - cyc_o/stb_o drop in the cycle after ack_i is sampled.
//   - Zero-wait slave: ack 2 cycles after request; a straddling fetch takes 4.
// - Requester drops en mid-cycle: the bus cycle completes; the result is discarded; no ack.
// - Back-to-back: after an ack, state returns to IDLE for at least one cycle.
// CONFIGURATION
// - MRU_FETCH_BUF_EN defined:
//   - One-entry buffer of the last fetched instruction word (address + data + valid).
//   - A fetch whose word(s) all hit the buffer acks in 1 cycle with no bus cycle.
//   - A data write to the buffered word invalidates it; reset clears valid.
// - MRU_FETCH_BUF_EN undefined: every fetch goes to the bus.
// TESTING
// - Write byte: mem_en=1, we=1, addr=32'h1, data=8'hAF -> adr_o=0, sel_o=4'b0010, dat_o=32'hAFAFAFAF, we_o=1; mem_ack pulses once.
// - Read it back: addr=32'h1, we=0 -> mem_data_o=8'hAF; lanes 0,2,3 unchanged.
// - Aligned fetch: word 0 = 32'h1234ABCD; ins_addr=0, ext=1 -> ins_data=32'h1234ABCD; ext=0 -> 32'h0000ABCD.
// - Straddle: word0=32'h1234ABCD, word1=32'h5678EF01; ins_addr=1, ext=1 -> two WB cycles (adr 0, 1) -> ins_data=32'hEF011234.
// - Simultaneous ins_en & mem_en with DATA_PRIO=1 -> data served first, ins_stl high until its own ack.
// - Assert rst_i low while cyc_o=1 -> cyc_o/stb_o fall without a clock edge; no acks after release.

Source files
------------

// File: rtl/mru_wb_bridge.sv
// Memory request unit: arbitrates instruction-fetch and byte data ports onto one classic Wishbone B4 master.
// Optional one-entry fetch buffer enabled by defining MRU_FETCH_BUF_EN.
module mru_wb_bridge #(
    parameter int DATA_PRIO = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ins_en,
    input  logic [30:0] ins_addr,
    input  logic        ins_ext,
    output logic        ins_stl,
    output logic        ins_ack,
    output logic [31:0] ins_data,
    input  logic        mem_en,
    input  logic [31:0] mem_addr,
    input  logic        mem_we,
    input  logic [7:0]  mem_data_i,
    output logic        mem_stl,
    output logic        mem_ack,
    output logic [7:0]  mem_data_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i,
    output logic [31:0] dat_o,
    output logic [29:0] adr_o,
    output logic [3:0]  sel_o,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o
);

    typedef enum logic [1:0] {IDLE, INS_A, INS_B, MEM} state_t;

    state_t      state_reg;
    logic        ins_odd_reg;
    logic        ins_ext_reg;
    logic [1:0]  mem_lane_reg;
    logic [15:0] low_half_reg;
    logic        take_mem;
    logic        take_ins;
    logic        ack_pending;
    logic [7:0]  rd_byte;

`ifdef MRU_FETCH_BUF_EN
    logic        buf_valid_reg;
    logic [29:0] buf_addr_reg;
    logic [31:0] buf_data_reg;
    logic        buf_hit;

    // A straddling fetch needs two words, so only single-word fetches can hit.
    assign buf_hit = buf_valid_reg && (buf_addr_reg == ins_addr[30:1]) && !(ins_addr[0] && ins_ext);
`endif

    assign ins_stl     = ins_en & ~ins_ack;
    assign mem_stl     = mem_en & ~mem_ack;
    assign stb_o       = cyc_o;
    assign ack_pending = ins_ack | mem_ack;
    assign take_mem    = mem_en & ((DATA_PRIO != 0) | ~ins_en);
    assign take_ins    = ins_en & ~take_mem;
    assign rd_byte     = dat_i[{mem_lane_reg, 3'b000} +: 8];

    function automatic logic [31:0] pick_ins(input logic [31:0] word, input logic odd, input logic ext);
        if (!odd && ext)
            return word;
        else if (!odd)
            return {16'h0, word[15:0]};
        else
            return {16'h0, word[31:16]};
    endfunction

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg    <= IDLE;
            cyc_o        <= 1'b0;
            we_o         <= 1'b0;
            sel_o        <= 4'h0;
            adr_o        <= 30'h0;
            dat_o        <= 32'h0;
            ins_ack      <= 1'b0;
            mem_ack      <= 1'b0;
            ins_data     <= 32'h0;
            mem_data_o   <= 8'h0;
            ins_odd_reg  <= 1'b0;
            ins_ext_reg  <= 1'b0;
            mem_lane_reg <= 2'b00;
            low_half_reg <= 16'h0;
`ifdef MRU_FETCH_BUF_EN
            buf_valid_reg <= 1'b0;
            buf_addr_reg  <= 30'h0;
            buf_data_reg  <= 32'h0;
`endif
        end else begin
            ins_ack <= 1'b0;
            mem_ack <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // During an ack cycle the requester still holds en for the old request.
                    if (!ack_pending) begin
                        if (take_mem) begin
                            state_reg    <= MEM;
                            cyc_o        <= 1'b1;
                            we_o         <= mem_we;
                            adr_o        <= mem_addr[31:2];
                            sel_o        <= 4'b0001 << mem_addr[1:0];
                            dat_o        <= {4{mem_data_i}};
                            mem_lane_reg <= mem_addr[1:0];
                        end else if (take_ins) begin
                            ins_odd_reg <= ins_addr[0];
                            ins_ext_reg <= ins_ext;
`ifdef MRU_FETCH_BUF_EN
                            if (buf_hit) begin
                                ins_ack  <= 1'b1;
                                ins_data <= pick_ins(buf_data_reg, ins_addr[0], ins_ext);
                            end else begin
                                state_reg <= INS_A;
                                cyc_o     <= 1'b1;
                                we_o      <= 1'b0;
                                adr_o     <= ins_addr[30:1];
                                sel_o     <= 4'hF;
                            end
`else
                            state_reg <= INS_A;
                            cyc_o     <= 1'b1;
                            we_o      <= 1'b0;
                            adr_o     <= ins_addr[30:1];
                            sel_o     <= 4'hF;
`endif
                        end
                    end
                end
                MEM: begin
                    if (ack_i) begin
                        state_reg <= IDLE;
                        cyc_o     <= 1'b0;
                        we_o      <= 1'b0;
                        if (mem_en) begin
                            mem_ack <= 1'b1;
                            if (!we_o)
                                mem_data_o <= rd_byte;
                        end
`ifdef MRU_FETCH_BUF_EN
                        if (we_o && (adr_o == buf_addr_reg))
                            buf_valid_reg <= 1'b0;
`endif
                    end
                end
                INS_A: begin
                    if (ack_i) begin
                        cyc_o <= 1'b0;
`ifdef MRU_FETCH_BUF_EN
                        buf_valid_reg <= 1'b1;
                        buf_addr_reg  <= adr_o;
                        buf_data_reg  <= dat_i;
`endif
                        if (ins_odd_reg && ins_ext_reg) begin
                            low_half_reg <= dat_i[31:16];
                            state_reg    <= INS_B;
                        end else begin
                            state_reg <= IDLE;
                            if (ins_en) begin
                                ins_ack  <= 1'b1;
                                ins_data <= pick_ins(dat_i, ins_odd_reg, ins_ext_reg);
                            end
                        end
                    end
                end
                INS_B: begin
                    // One idle bus cycle separates the two halves of a straddling fetch.
                    if (!cyc_o) begin
                        cyc_o <= 1'b1;
                        adr_o <= adr_o + 30'd1;
                    end else if (ack_i) begin
                        cyc_o     <= 1'b0;
                        state_reg <= IDLE;
`ifdef MRU_FETCH_BUF_EN
                        buf_valid_reg <= 1'b1;
                        buf_addr_reg  <= adr_o;
                        buf_data_reg  <= dat_i;
`endif
                        if (ins_en) begin
                            ins_ack  <= 1'b1;
                            ins_data <= {dat_i[15:0], low_half_reg};
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mru_wb_bridge.sv
// Self-checking bench for mru_wb_bridge: Wishbone memory slave, byte-array reference model,
// directed vector table, hand sequences for arbitration/abort/reset, then randomized traffic.
module tb_mru_wb_bridge;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        ins_en = 1'b0;
    logic [30:0] ins_addr = '0;
    logic        ins_ext = 1'b0;
    logic        ins_stl, ins_ack;
    logic [31:0] ins_data;
    logic        mem_en = 1'b0;
    logic [31:0] mem_addr = '0;
    logic        mem_we = 1'b0;
    logic [7:0]  mem_data_i = '0;
    logic        mem_stl, mem_ack;
    logic [7:0]  mem_data_o;
    logic [31:0] dat_i;
    logic        ack_i;
    logic [31:0] dat_o;
    logic [29:0] adr_o;
    logic [3:0]  sel_o;
    logic        cyc_o, stb_o, we_o;

    always #5 clk_i = ~clk_i;

    mru_wb_bridge #(.DATA_PRIO(1)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ins_en(ins_en), .ins_addr(ins_addr), .ins_ext(ins_ext),
        .ins_stl(ins_stl), .ins_ack(ins_ack), .ins_data(ins_data),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_we(mem_we), .mem_data_i(mem_data_i),
        .mem_stl(mem_stl), .mem_ack(mem_ack), .mem_data_o(mem_data_o),
        .dat_i(dat_i), .ack_i(ack_i), .dat_o(dat_o), .adr_o(adr_o), .sel_o(sel_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o)
    );

    // Wishbone slave: 16-word memory, combinational ack gated by a per-cycle ready flag.
    logic [31:0] slv_mem [16];
    logic        ack_ok = 1'b0;
    logic        zero_wait = 1'b1;
    logic        slave_hold = 1'b0;

    assign ack_i = cyc_o & stb_o & ack_ok;
    assign dat_i = slv_mem[adr_o[3:0]];

    always @(negedge clk_i)
        ack_ok = slave_hold ? 1'b0 : (zero_wait ? 1'b1 : ($urandom_range(0, 2) == 0));

    always @(posedge clk_i) begin
        if (ack_i && we_o) begin
            for (int l = 0; l < 4; l++)
                if (sel_o[l])
                    slv_mem[adr_o[3:0]][8*l +: 8] <= dat_o[8*l +: 8];
        end
    end

    // Reference model: flat little-endian byte memory.
    logic [7:0] ref_bytes [64];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [15:0] ref_half(input int k);
        return {ref_bytes[(2*k+1) % 64], ref_bytes[(2*k) % 64]};
    endfunction

    function automatic logic [31:0] ref_fetch(input int a, input bit ext);
        if (ext)
            return {ref_half(a + 1), ref_half(a)};
        return {16'h0, ref_half(a)};
    endfunction

    task automatic set_word(input int w, input logic [31:0] v);
        slv_mem[w] = v;
        for (int b = 0; b < 4; b++)
            ref_bytes[4*w + b] = v[8*b +: 8];
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_mem(input logic [31:0] a, input logic w, input logic [7:0] d,
                          input string tag, output logic [7:0] rd);
        int n;
        bit seen;
        logic [29:0] cadr;
        logic [3:0] csel;
        logic [31:0] cdat;
        logic cwe;
        logic [3:0] one;
        n = 0; seen = 0; cadr = '0; csel = '0; cdat = '0; cwe = 0;
        @(posedge clk_i); #1;
        mem_en = 1'b1; mem_addr = a; mem_we = w; mem_data_i = d;
        for (n = 1; n <= 60; n++) begin
            @(negedge clk_i);
            if (cyc_o && !seen) begin
                seen = 1; cadr = adr_o; csel = sel_o; cdat = dat_o; cwe = we_o;
            end
            if (mem_ack) break;
        end
        rd = mem_data_o;
        if (!mem_ack) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: timeout waiting for mem_ack", tag);
        end else begin
            one = 4'b0001;
            check({tag, " adr_o"}, {2'b0, cadr}, {2'b0, a[31:2]});
            check({tag, " sel_o"}, {28'h0, csel}, {28'h0, one << a[1:0]});
            check({tag, " we_o"}, {31'h0, cwe}, {31'h0, w});
            if (w) begin
                check({tag, " dat_o"}, cdat, {4{d}});
                ref_bytes[a[5:0]] = d;
            end
            check({tag, " mem_stl"}, {31'h0, mem_stl}, 32'h0);
            if (zero_wait)
                check({tag, " latency"}, n - 1, 2);
        end
        $display("mem %s addr=%h we=%0d wdata=%h rdata=%h cycles=%0d", tag, a, w, d, rd, n - 1);
        @(posedge clk_i); #1;
        mem_en = 1'b0;
        @(negedge clk_i);
        check({tag, " mem_ack single pulse"}, {31'h0, mem_ack}, 32'h0);
    endtask

    task automatic do_fetch(input int a, input bit ext, input string tag, output logic [31:0] dout);
        int n;
        bit seen;
        bit straddle;
        logic [29:0] first_adr, last_adr;
        logic [3:0] csel;
        n = 0; seen = 0; first_adr = '0; last_adr = '0; csel = '0;
        straddle = ext && (a % 2 == 1);
        @(posedge clk_i); #1;
        ins_en = 1'b1; ins_addr = a[30:0]; ins_ext = ext;
        for (n = 1; n <= 60; n++) begin
            @(negedge clk_i);
            if (cyc_o) begin
                if (!seen) begin
                    seen = 1; first_adr = adr_o; csel = sel_o;
                end
                last_adr = adr_o;
            end
            if (ins_ack) break;
        end
        dout = ins_data;
        if (!ins_ack) begin
            n_cmp++; n_bad++;
            $display("FAIL %s: timeout waiting for ins_ack", tag);
        end else begin
            check({tag, " first adr_o"}, {2'b0, first_adr}, a / 2);
            if (straddle)
                check({tag, " second adr_o"}, {2'b0, last_adr}, a / 2 + 1);
            check({tag, " sel_o"}, {28'h0, csel}, 32'hF);
            if (zero_wait)
                check({tag, " latency"}, n - 1, straddle ? 4 : 2);
        end
        $display("fetch %s addr=%0d ext=%0d data=%h cycles=%0d", tag, a, ext, dout, n - 1);
        @(posedge clk_i); #1;
        ins_en = 1'b0;
        @(negedge clk_i);
        check({tag, " ins_ack single pulse"}, {31'h0, ins_ack}, 32'h0);
    endtask

    typedef struct {
        bit          is_ins;
        bit          we;
        logic [31:0] addr;
        logic [7:0]  wd;
        bit          ext;
        bit          has_exp;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic [7:0]  rd;
        logic [31:0] idat;
        logic [31:0] expv;
        int mem_at, ins_at, bad_cnt, acks;
        bit w, e;
        int a;
        logic [7:0] d;

        for (int i = 0; i < 16; i++)
            set_word(i, $urandom);
        set_word(0, 32'h1234ABCD);
        set_word(1, 32'h5678EF01);

        vecs[0] = '{1, 0, 32'd0, 8'h00, 1, 1, 32'h1234ABCD};
        vecs[1] = '{1, 0, 32'd0, 8'h00, 0, 1, 32'h0000ABCD};
        vecs[2] = '{1, 0, 32'd1, 8'h00, 1, 1, 32'hEF011234};
        vecs[3] = '{1, 0, 32'd1, 8'h00, 0, 1, 32'h00001234};
        vecs[4] = '{0, 1, 32'h1, 8'hAF, 0, 0, 32'h0};
        vecs[5] = '{0, 0, 32'h1, 8'h00, 0, 1, 32'h000000AF};
        vecs[6] = '{0, 0, 32'h0, 8'h00, 0, 1, 32'h000000CD};
        vecs[7] = '{0, 0, 32'h2, 8'h00, 0, 1, 32'h00000034};
        vecs[8] = '{0, 0, 32'h3, 8'h00, 0, 1, 32'h00000012};
        vecs[9] = '{1, 0, 32'd0, 8'h00, 1, 1, 32'h1234AFCD};

        // Reset state
        repeat (2) @(negedge clk_i);
        check("reset cyc_o", {31'h0, cyc_o}, 32'h0);
        check("reset stb_o", {31'h0, stb_o}, 32'h0);
        check("reset we_o", {31'h0, we_o}, 32'h0);
        check("reset acks", {30'h0, ins_ack, mem_ack}, 32'h0);
        check("reset sel_o", {28'h0, sel_o}, 32'h0);
        check("reset adr_o", {2'b0, adr_o}, 32'h0);
        check("reset dat_o", dat_o, 32'h0);
        check("reset ins_data", ins_data, 32'h0);
        check("reset mem_data_o", {24'h0, mem_data_o}, 32'h0);
        rst_i = 1'b1;

        // Directed vector table, zero-wait slave
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].is_ins) begin
                do_fetch(int'(vecs[i].addr), vecs[i].ext, $sformatf("vec%0d", i), idat);
                check($sformatf("vec%0d ins_data", i), idat, vecs[i].exp);
            end else begin
                do_mem(vecs[i].addr, vecs[i].we, vecs[i].wd, $sformatf("vec%0d", i), rd);
                if (vecs[i].has_exp)
                    check($sformatf("vec%0d mem_data_o", i), {24'h0, rd}, vecs[i].exp);
            end
        end

        // Requester drops ins_en while its bus cycle is open: no ack, data kept
        idat = ins_data;
        @(posedge clk_i); #1;
        ins_en = 1'b1; ins_addr = 31'd2; ins_ext = 1'b0;
        for (int n = 0; n < 20 && !cyc_o; n++) @(negedge clk_i);
        check("abort cyc_o seen", {31'h0, cyc_o}, 32'h1);
        ins_en = 1'b0;
        acks = 0;
        repeat (5) begin
            @(negedge clk_i);
            if (ins_ack) acks++;
        end
        check("abort no ins_ack", acks, 0);
        check("abort ins_data held", ins_data, idat);
        check("abort cyc_o dropped", {31'h0, cyc_o}, 32'h0);
        $display("abort fetch addr=2 acks=%0d", acks);

        // Simultaneous requests: data port wins, fetch stalls until its own ack
        expv = ref_fetch(0, 1);
        rd = ref_bytes[4];
        @(posedge clk_i); #1;
        ins_en = 1'b1; ins_addr = 31'd0; ins_ext = 1'b1;
        mem_en = 1'b1; mem_addr = 32'h4; mem_we = 1'b0;
        mem_at = 0; ins_at = 0;
        for (int n = 1; n <= 60 && (mem_at == 0 || ins_at == 0); n++) begin
            @(negedge clk_i);
            if (mem_ack) begin
                mem_at = n;
                check("prio ins_stl during mem_ack", {31'h0, ins_stl}, 32'h1);
                check("prio mem_data_o", {24'h0, mem_data_o}, {24'h0, rd});
            end
            if (ins_ack) begin
                ins_at = n;
                check("prio ins_data", ins_data, expv);
            end
            @(posedge clk_i); #1;
            if (mem_at == n) mem_en = 1'b0;
            if (ins_at == n) ins_en = 1'b0;
        end
        ins_en = 1'b0; mem_en = 1'b0;
        check("prio data first", {31'h0, (mem_at != 0 && ins_at > mem_at)}, 32'h1);
        $display("prio mem_ack@%0d ins_ack@%0d", mem_at, ins_at);

        // Randomized traffic with random wait states
        zero_wait = 1'b0;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                a = $urandom_range(0, 63);
                w = $urandom_range(0, 1);
                d = 8'($urandom);
                expv = {24'h0, ref_bytes[a]};
                do_mem(a, w, d, $sformatf("rnd%0d", i), rd);
                if (!w)
                    check($sformatf("rnd%0d mem_data_o", i), {24'h0, rd}, expv);
            end else begin
                a = $urandom_range(0, 30);
                e = $urandom_range(0, 1);
                expv = ref_fetch(a, e);
                do_fetch(a, e, $sformatf("rnd%0d", i), idat);
                check($sformatf("rnd%0d ins_data", i), idat, expv);
            end
        end

        // Reset mid-transaction: cyc/stb fall asynchronously, no ack afterwards
        zero_wait = 1'b1;
        slave_hold = 1'b1;
        @(posedge clk_i); #1;
        mem_en = 1'b1; mem_addr = 32'h8; mem_we = 1'b0;
        for (int n = 0; n < 20 && !cyc_o; n++) @(negedge clk_i);
        check("rst cyc_o before reset", {31'h0, cyc_o}, 32'h1);
        #2;
        rst_i = 1'b0;
        #1;
        check("rst async cyc_o", {31'h0, cyc_o}, 32'h0);
        check("rst async stb_o", {31'h0, stb_o}, 32'h0);
        check("rst mem_data_o", {24'h0, mem_data_o}, 32'h0);
        check("rst ins_data", ins_data, 32'h0);
        mem_en = 1'b0;
        slave_hold = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        bad_cnt = 0;
        repeat (6) begin
            @(negedge clk_i);
            if (ins_ack || mem_ack || cyc_o) bad_cnt++;
        end
        check("rst no activity after release", bad_cnt, 0);
        $display("reset mid-cycle activity_after=%0d", bad_cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
